// File: rtl/ysyx_22041207_mem_arbiter.sv
// Two-requester arbiter for the single data-memory port.
// IF (fetch, read-only) and ME (load/store) share one downstream port.
// ME normally wins. After STARVE_LIMIT lost contentions in a row, IF wins
// the next contention. Exactly one transaction is in flight at a time:
// IDLE (arbitrate) -> ISSUE (present request) -> WAIT (await response).
//
// Handshakes: a transfer happens on a cycle where valid and ready are both
// high. A requester keeps valid and its fields steady until it sees ready.
// In IDLE, ready is a combinational function of the current valids.
// mem_req_valid stays high in ISSUE, with the latched fields held, until
// mem_req_ready. Each response is a single-cycle rvalid pulse, routed to the
// owner of the transaction only while in WAIT.
module ysyx_22041207_mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int AW           = 64,
  parameter int DW           = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [AW-1:0]     if_addr,
  output logic              if_rvalid,
  output logic [DW-1:0]     if_rdata,
  input  logic              me_req_valid,
  output logic              me_req_ready,
  input  logic [AW-1:0]     me_addr,
  input  logic              me_wen,
  input  logic [DW-1:0]     me_wdata,
  input  logic [DW/8-1:0]   me_wmask,
  output logic              me_rvalid,
  output logic [DW-1:0]     me_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [AW-1:0]     mem_addr,
  output logic              mem_wen,
  output logic [DW-1:0]     mem_wdata,
  output logic [DW/8-1:0]   mem_wmask,
  input  logic              mem_rvalid,
  input  logic [DW-1:0]     mem_rdata,
  output logic              busy
);

  localparam int         MW    = DW / 8;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t          state;
  logic            owner_me;
  logic [3:0]      starve_cnt;
  logic [AW-1:0]   addr_q;
  logic            wen_q;
  logic [DW-1:0]   wdata_q;
  logic [MW-1:0]   wmask_q;

  logic            arb_en;
  logic            both_valid;
  logic            if_win;
  logic            me_win;
  logic            resp_en;

  // Arbitration: only while idle and out of reset; IF wins alone or when starved
  always_comb begin
    arb_en     = (state == S_IDLE) && !rst;
    both_valid = if_req_valid && me_req_valid;
    if_win     = arb_en && if_req_valid && (!me_req_valid || (starve_cnt == LIMIT));
    me_win     = arb_en && me_req_valid && !(if_req_valid && (starve_cnt == LIMIT));
    resp_en    = (state == S_WAIT) && !rst;
  end

  // Transaction FSM: latch the winner, issue downstream, wait for the response
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      owner_me   <= 1'b0;
      starve_cnt <= 4'd0;
      addr_q     <= '0;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      wmask_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (if_win) begin
            addr_q     <= if_addr;
            wen_q      <= 1'b0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            owner_me   <= 1'b0;
            starve_cnt <= 4'd0;
            state      <= S_ISSUE;
          end else if (me_win) begin
            addr_q   <= me_addr;
            wen_q    <= me_wen;
            wdata_q  <= me_wdata;
            wmask_q  <= me_wmask;
            owner_me <= 1'b1;
            // Only a contended loss counts against IF; saturate at the limit
            if (both_valid && (starve_cnt < LIMIT)) begin
              starve_cnt <= starve_cnt + 4'd1;
            end
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (mem_req_ready) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign if_req_ready  = if_win;
  assign me_req_ready  = me_win;

  assign mem_req_valid = (state == S_ISSUE) && !rst;
  assign mem_addr      = addr_q;
  assign mem_wen       = wen_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;

  // Responses reach only the owner and only while waiting for one
  assign if_rvalid = resp_en && !owner_me && mem_rvalid;
  assign me_rvalid = resp_en &&  owner_me && mem_rvalid;
  assign if_rdata  = (resp_en && !owner_me) ? mem_rdata : '0;
  assign me_rdata  = (resp_en &&  owner_me) ? mem_rdata : '0;

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_ysyx_22041207_mem_arbiter.sv
// Bench for ysyx_22041207_mem_arbiter: directed scenarios plus randomised
// two-requester traffic against a memory responder with tunable delays.
module tb_ysyx_22041207_mem_arbiter;

  localparam int AW    = 64;
  localparam int DW    = 64;
  localparam int MW    = DW / 8;
  localparam int LIMIT = 4;

  localparam int M_IDLE  = 0;
  localparam int M_ISSUE = 1;
  localparam int M_WAIT  = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic            if_req_valid, if_req_ready, if_rvalid;
  logic [AW-1:0]   if_addr;
  logic [DW-1:0]   if_rdata;
  logic            me_req_valid, me_req_ready, me_wen, me_rvalid;
  logic [AW-1:0]   me_addr;
  logic [DW-1:0]   me_wdata, me_rdata;
  logic [MW-1:0]   me_wmask;
  logic            mem_req_valid, mem_req_ready, mem_wen, mem_rvalid;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata, mem_rdata;
  logic [MW-1:0]   mem_wmask;
  logic            busy;

  // Memory side: automatic responder OR directed injection
  logic            r_ready, r_rvalid;
  logic [DW-1:0]   r_rdata;
  logic            inj_ready, inj_rvalid;
  logic [DW-1:0]   inj_rdata;
  logic            mem_auto;
  int              rdy_dly, resp_dly;

  assign mem_req_ready = r_ready | inj_ready;
  assign mem_rvalid    = r_rvalid | inj_rvalid;
  assign mem_rdata     = inj_rvalid ? inj_rdata : r_rdata;

  ysyx_22041207_mem_arbiter #(.STARVE_LIMIT(LIMIT), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .me_req_valid(me_req_valid), .me_req_ready(me_req_ready), .me_addr(me_addr),
    .me_wen(me_wen), .me_wdata(me_wdata), .me_wmask(me_wmask),
    .me_rvalid(me_rvalid), .me_rdata(me_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Memory contents as seen by the bench
  function automatic logic [63:0] mem_fn(input logic [63:0] a);
    if (a == 64'h8000_0000) return 64'h0000_0513;
    return {a[31:0] ^ 32'h5A5A_1234, ~a[31:0]};
  endfunction

  // ---------------- memory responder ----------------
  logic [AW-1:0] paddr;
  logic          pend;
  int            wcnt, rcnt;

  initial begin
    r_ready = 1'b0; r_rvalid = 1'b0; r_rdata = '0;
    pend = 1'b0; wcnt = 0; rcnt = 0; paddr = '0;
    forever begin
      @(posedge clk); #2;
      r_ready = 1'b0; r_rvalid = 1'b0; r_rdata = '0;
      if (!mem_auto) begin
        pend = 1'b0; wcnt = 0; rcnt = 0;
      end else if (pend) begin
        if (rcnt >= resp_dly) begin
          r_rvalid = 1'b1; r_rdata = mem_fn(paddr); pend = 1'b0; rcnt = 0;
        end else rcnt++;
      end else if (mem_req_valid) begin
        if (wcnt >= rdy_dly) begin
          r_ready = 1'b1; pend = 1'b1; paddr = mem_addr; wcnt = 0;
        end else wcnt++;
      end
    end
  end

  // ---------------- reference model + scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  int            m_state = M_IDLE;
  int            m_starve = 0;
  logic          m_owner_me;
  logic [AW-1:0] m_addr;
  logic          m_wen;
  logic [DW-1:0] m_wdata;
  logic [MW-1:0] m_wmask;
  logic          e_if, e_me;
  logic [DW-1:0] e_data;

  // Sample at negedge; model state advances on the events seen this cycle
  always @(negedge clk) begin
    if (rst) begin
      check("rst_if_ready",  if_req_ready,  0);
      check("rst_me_ready",  me_req_ready,  0);
      check("rst_if_rvalid", if_rvalid,     0);
      check("rst_me_rvalid", me_rvalid,     0);
      check("rst_mem_valid", mem_req_valid, 0);
      m_state  = M_IDLE;
      m_starve = 0;
      exp_q.delete();
    end else begin
      check("busy", busy, (m_state != M_IDLE));
      case (m_state)
        M_IDLE: begin
          e_if = if_req_valid && (!me_req_valid || (m_starve == LIMIT));
          e_me = me_req_valid && !e_if;
          check("if_ready", if_req_ready, e_if);
          check("me_ready", me_req_ready, e_me);
          check("idle_mem_valid", mem_req_valid, 0);
          check("idle_if_rvalid", if_rvalid, 0);
          check("idle_me_rvalid", me_rvalid, 0);
          if (e_if) begin
            m_owner_me = 1'b0; m_addr = if_addr; m_wen = 1'b0; m_wmask = '0; m_wdata = '0;
            exp_q.push_back(mem_fn(if_addr));
            m_starve = 0;
            m_state  = M_ISSUE;
          end else if (e_me) begin
            m_owner_me = 1'b1; m_addr = me_addr; m_wen = me_wen; m_wmask = me_wmask; m_wdata = me_wdata;
            exp_q.push_back(mem_fn(me_addr));
            if (if_req_valid && (m_starve < LIMIT)) m_starve++;
            m_state = M_ISSUE;
          end
        end
        M_ISSUE: begin
          check("issue_mem_valid", mem_req_valid, 1);
          check("issue_addr",  mem_addr,  m_addr);
          check("issue_wen",   mem_wen,   m_wen);
          check("issue_wmask", mem_wmask, m_wmask);
          if (m_owner_me) check("issue_wdata", mem_wdata, m_wdata);
          check("issue_if_ready", if_req_ready, 0);
          check("issue_me_ready", me_req_ready, 0);
          check("issue_if_rvalid", if_rvalid, 0);
          check("issue_me_rvalid", me_rvalid, 0);
          if (mem_req_ready) m_state = M_WAIT;
        end
        default: begin
          check("wait_mem_valid", mem_req_valid, 0);
          check("wait_if_ready", if_req_ready, 0);
          check("wait_me_ready", me_req_ready, 0);
          check("wait_if_rvalid", if_rvalid, mem_rvalid && !m_owner_me);
          check("wait_me_rvalid", me_rvalid, mem_rvalid &&  m_owner_me);
          if (m_owner_me) check("wait_if_rdata_zero", if_rdata, 0);
          else            check("wait_me_rdata_zero", me_rdata, 0);
          if (mem_rvalid) begin
            if (exp_q.size() == 0) begin
              check("resp_without_request", 1, 0);
            end else begin
              e_data = exp_q.pop_front();
              check("resp_rdata", m_owner_me ? me_rdata : if_rdata, e_data);
            end
            m_state = M_IDLE;
          end
        end
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  bit grant_log[$];   // 1 = IF granted, 0 = ME granted

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Keeps requests flowing until n_if/n_me new ones plus any already-raised
  // valids have completed; logs the grant order.
  task automatic run_traffic(input int n_if, input int n_me, input string tag);
    int   if_left, me_left, cyc;
    logic gi, gm;
    if_left = n_if; me_left = n_me; cyc = 0;
    grant_log.delete();
    forever begin
      @(negedge clk);
      gi = if_req_valid && if_req_ready;
      gm = me_req_valid && me_req_ready;
      if (gi) grant_log.push_back(1'b1);
      if (gm) grant_log.push_back(1'b0);
      if (if_left == 0 && me_left == 0 && !if_req_valid && !me_req_valid &&
          m_state == M_IDLE && exp_q.size() == 0) break;
      cyc++;
      if (cyc > 600) begin
        $display("FAIL %s_timeout: still pending after %0d cycles, required done", tag, cyc);
        n_checks++; n_fail++;
        break;
      end
      step();
      if (gi) if_req_valid = 1'b0;
      if (gm) me_req_valid = 1'b0;
      if (!if_req_valid && if_left > 0) begin
        if_addr = 64'h8000_0000 + 64'($urandom_range(0, 4095)) * 4;
        if_req_valid = 1'b1;
        if_left--;
      end
      if (!me_req_valid && me_left > 0) begin
        me_addr  = 64'h8000_4000 + 64'($urandom_range(0, 4095)) * 8;
        me_wen   = 1'($urandom_range(0, 1));
        me_wdata = {$urandom, $urandom};
        me_wmask = 8'($urandom_range(0, 255));
        me_req_valid = 1'b1;
        me_left--;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  int   issue_n, ack_n;
  bit   starve_exp[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
  logic first_g;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; mem_auto = 1'b0; rdy_dly = 0; resp_dly = 0;
    inj_ready = 1'b0; inj_rvalid = 1'b0; inj_rdata = '0;
    if_req_valid = 1'b1; if_addr = 64'h8000_0100;
    me_req_valid = 1'b1; me_addr = 64'h8000_0200; me_wen = 1'b0;
    me_wdata = '0; me_wmask = '0;

    // Reset with both valids high, then ME must win first
    repeat (2) @(posedge clk);
    #1; rst = 1'b0; mem_auto = 1'b1;
    run_traffic(0, 0, "release");
    first_g = (grant_log.size() > 0) ? grant_log[0] : 1'b1;
    check("first_grant_is_me", first_g, 0);
    check("release_grants", grant_log.size(), 2);

    // Single IF read, minimum latency
    step(); if_addr = 64'h8000_0000; if_req_valid = 1'b1;
    @(negedge clk); check("t0_if_ready", if_req_ready, 1);
    step(); if_req_valid = 1'b0;
    @(negedge clk);
    check("t1_mem_valid", mem_req_valid, 1);
    check("t1_mem_addr", mem_addr, 64'h8000_0000);
    check("t1_mem_wmask", mem_wmask, 0);
    step();
    @(negedge clk);
    check("t2_if_rvalid", if_rvalid, 1);
    check("t2_if_rdata", if_rdata, 64'h0000_0513);
    check("t2_me_rvalid", me_rvalid, 0);

    // ME write with downstream back-pressure
    rdy_dly = 3;
    step();
    me_addr = 64'h8000_1000; me_wen = 1'b1; me_wdata = 64'hDEAD_BEEF; me_wmask = 8'h0F;
    me_req_valid = 1'b1;
    @(negedge clk); check("w_me_ready", me_req_ready, 1);
    issue_n = 0; ack_n = 0;
    for (int i = 0; i < 10; i++) begin
      step(); me_req_valid = 1'b0;
      @(negedge clk);
      if (mem_req_valid) begin
        issue_n++;
        check("w_wdata", mem_wdata, 64'hDEAD_BEEF);
        check("w_wmask", mem_wmask, 8'h0F);
        check("w_wen", mem_wen, 1);
      end
      if (me_rvalid) ack_n++;
    end
    check("w_issue_cycles", issue_n, 4);
    check("w_ack_pulses", ack_n, 1);
    rdy_dly = 0;

    // Reset while in WAIT, then a late response arrives
    step(); mem_auto = 1'b0; if_addr = 64'h8000_2000; if_req_valid = 1'b1;
    @(negedge clk); check("rm_if_ready", if_req_ready, 1);
    step(); if_req_valid = 1'b0; inj_ready = 1'b1;
    @(negedge clk); check("rm_issue", mem_req_valid, 1);
    step(); inj_ready = 1'b0; rst = 1'b1;
    @(negedge clk);
    step(); rst = 1'b0;
    @(negedge clk); check("rm_busy_after_rst", busy, 0);
    step(); inj_rvalid = 1'b1; inj_rdata = 64'h1234;
    @(negedge clk);
    check("rm_if_rvalid", if_rvalid, 0);
    check("rm_me_rvalid", me_rvalid, 0);
    step(); inj_rvalid = 1'b0;
    @(negedge clk); check("rm_stays_idle", busy, 0);

    // Stray responses in IDLE and ISSUE
    step(); inj_rvalid = 1'b1; inj_rdata = 64'hBAD;
    @(negedge clk);
    check("stray_idle_if_rvalid", if_rvalid, 0);
    check("stray_idle_me_rvalid", me_rvalid, 0);
    check("stray_idle_busy", busy, 0);
    step(); inj_rvalid = 1'b0;
    me_addr = 64'h8000_3000; me_wen = 1'b0; me_wdata = '0; me_wmask = '0; me_req_valid = 1'b1;
    @(negedge clk); check("stray_me_ready", me_req_ready, 1);
    step(); me_req_valid = 1'b0; inj_rvalid = 1'b1; inj_rdata = 64'hBAD;
    @(negedge clk);
    check("stray_issue_me_rvalid", me_rvalid, 0);
    check("stray_issue_valid", mem_req_valid, 1);
    step(); inj_rvalid = 1'b0; inj_ready = 1'b1;
    @(negedge clk); check("stray_still_issue", mem_req_valid, 1);
    step(); inj_ready = 1'b0; inj_rvalid = 1'b1; inj_rdata = mem_fn(64'h8000_3000);
    @(negedge clk);
    check("stray_real_me_rvalid", me_rvalid, 1);
    check("stray_real_me_rdata", me_rdata, mem_fn(64'h8000_3000));
    step(); inj_rvalid = 1'b0;
    @(negedge clk); check("stray_back_idle", busy, 0);

    // Starvation guard: ME x4, IF, ME x4, IF
    step(); rst = 1'b1;
    step(); rst = 1'b0; mem_auto = 1'b1; rdy_dly = 0; resp_dly = 0;
    run_traffic(2, 8, "starve");
    check("starve_grant_count", grant_log.size(), 10);
    for (int i = 0; i < 10; i++) begin
      if (i < grant_log.size()) check($sformatf("starve_grant_%0d", i), grant_log[i], starve_exp[i]);
    end

    // Randomised mixed traffic with varied memory timing
    for (int c = 0; c < 3; c++) begin
      rdy_dly  = $urandom_range(0, 2);
      resp_dly = $urandom_range(0, 3);
      run_traffic(6, 6, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_22041207_mem_arbiter.md
Name: ysyx_22041207_mem_arbiter

Overview:
- Shares the single data-memory port between the instruction fetch requester (IF, read-only) and the memory-stage requester (ME, read/write).
- Sits between the IF/ME pipeline stages and the memory model. Serialises one transaction at a time.
- Fixed ME priority, with a starvation guard that grants IF after a bounded number of losses.

Parameters:
- STARVE_LIMIT, 4: consecutive lost arbitrations after which IF wins the next contention. Legal range 1..15.
- AW, 64: address width.
- DW, 64: data width. Write mask is DW/8 bits.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- if_req_valid  in  1  IF read request
- if_req_ready  out  1  IF request accepted this cycle
- if_addr  in  AW  IF fetch address
- if_rvalid  out  1  IF response pulse
- if_rdata  out  DW  IF response data
- me_req_valid  in  1  ME request
- me_req_ready  out  1  ME request accepted this cycle
- me_addr  in  AW  ME address
- me_wen  in  1  1 = write, 0 = read
- me_wdata  in  DW  ME write data
- me_wmask  in  DW/8  ME byte write mask
- me_rvalid  out  1  ME response pulse (read data or write ack)
- me_rdata  out  DW  ME read data
- mem_req_valid  out  1  downstream request
- mem_req_ready  in  1  downstream accepts request
- mem_addr  out  AW  latched address
- mem_wen  out  1  latched write enable
- mem_wdata  out  DW  latched write data
- mem_wmask  out  DW/8  latched mask; forced 0 for IF
- mem_rvalid  in  1  downstream response / write ack
- mem_rdata  in  DW  downstream read data
- busy  out  1  state != IDLE

Behaviour:
- States: IDLE, ISSUE, WAIT. Reset (rst=1 at a clk edge):
  - state=IDLE, owner=IF, starve_cnt=0.
  - All latched request registers cleared to 0.
  - All *_ready, *_rvalid, mem_req_valid and busy deassert.
- IDLE, arbitration is combinational on the current valids:
  - Only IF valid: grant IF.
  - Only ME valid: grant ME.
  - Both valid: grant IF if starve_cnt == STARVE_LIMIT, else grant ME.
  - Granted requester's *_req_ready = 1 for exactly this cycle. Its addr/wen/wdata/wmask are latched (IF: wen=0, wmask=0), owner is recorded, and the next state is ISSUE.
  - No valid: stay in IDLE, all ready = 0.
- starve_cnt, updated only on IDLE grant cycles:
  - Both valid and ME granted: increment, saturating at STARVE_LIMIT.
  - IF granted: reset to 0.
  - Otherwise: hold.
- ISSUE:
  - mem_req_valid = 1 with the latched fields held stable.
  - mem_req_ready = 1: go to WAIT. Otherwise stay in ISSUE.
  - Both requester ready outputs = 0.
- WAIT:
  - mem_req_valid = 0.
  - On mem_rvalid: the owner's *_rvalid = mem_rvalid combinationally (single-cycle pulse), the owner's *_rdata = mem_rdata, next state IDLE.
  - The non-owner's rvalid stays 0 and its rdata is 0.
- Latency:
  - Accept to mem_req_valid: 1 cycle.
  - Minimum accept to response: 2 cycles, when mem_req_ready is high in ISSUE and mem_rvalid is high on the first WAIT cycle.
  - A new grant is possible in the cycle after the response, which is IDLE. Back-to-back throughput is 1 transaction per 3 cycles minimum.
- Boundary conditions:
  - mem_rvalid in IDLE or ISSUE is ignored and not routed.
  - mem_rvalid and mem_req_ready are never combined within a single state.
  - Requester valid changes while not granted have no effect. A requester holds valid until it sees ready.
  - Write transactions: me_rvalid pulses as the ack. me_rdata reflects mem_rdata and is don't-care to the consumer.
  - rst during ISSUE or WAIT aborts the transaction: state returns to IDLE and no rvalid is generated. A later stray mem_rvalid is ignored by the IDLE rule.
  - rst has priority over every other event in the same cycle.

Test Plan:
- Reset then idle: rst=1 for 2 cycles with both valids high → all ready/rvalid/mem_req_valid = 0 and busy = 0. After release, ME is granted first.
- Single IF read: if_addr=0x80000000, mem_req_ready=1, mem_rvalid=1 with mem_rdata=0x00000513 one cycle later → if_req_ready at T0, mem_req_valid with mem_addr=0x80000000 and mem_wmask=0 at T1, if_rvalid with if_rdata=0x00000513 at T2, me_rvalid stays 0.
- ME write: me_addr=0x80001000, wdata=0xDEADBEEF, wmask=0x0F, mem_req_ready held 0 for 3 cycles → mem fields stay stable for 3 cycles, then accepted; me_rvalid pulses exactly once on the ack.
- Starvation: both valid continuously, STARVE_LIMIT=4, memory responds in minimum time → grant order is ME, ME, ME, ME, IF, ME…; starve_cnt returns to 0 after the IF grant.
- Reset mid-transaction: rst asserted in WAIT, then mem_rvalid=1 arrives one cycle after rst release → no if_rvalid or me_rvalid, state stays IDLE.
- Stray response: mem_rvalid=1 while in IDLE or ISSUE → no requester rvalid, and no state change from that stray response.
